// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory responder: FSM state encoding,
// request kinds and the default widths used by the responder and its bus.
package mem_responder_pkg;

    localparam int WORD_WIDTH = 32;
    localparam int RAM_ADDR_W = 12;
    localparam int BE_WIDTH   = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } mem_state_t;

    typedef enum logic [1:0] {
        REQ_FETCH = 2'd0,
        REQ_LOAD  = 2'd1,
        REQ_STORE = 2'd2
    } req_kind_t;

    // A byte address that does not fall on a word boundary.
    function automatic logic misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// CPU-side bus of the memory responder: fetch, load and store strobes with
// their address/data, plus the returned words and status flags.
interface mem_responder_if
    import mem_responder_pkg::*;
#(
    parameter int W = WORD_WIDTH
);
    logic                pc_clk;
    logic [W-1:0]        pc;
    logic [W-1:0]        inst;
    logic                load_clk;
    logic                load_en;
    logic [W-1:0]        l_addr;
    logic [W-1:0]        l_data;
    logic                store_clk;
    logic                store_en;
    logic [W-1:0]        s_addr;
    logic [W-1:0]        s_data;
    logic [BE_WIDTH-1:0] s_be;
    logic                busy;
    logic                addr_err;

    // CPU side
    modport master (
        output pc_clk, pc, load_clk, load_en, l_addr,
               store_clk, store_en, s_addr, s_data, s_be,
        input  inst, l_data, busy, addr_err
    );

    // Responder side
    modport slave (
        input  pc_clk, pc, load_clk, load_en, l_addr,
               store_clk, store_en, s_addr, s_data, s_be,
        output inst, l_data, busy, addr_err
    );

endinterface

// File: rtl/mem_responder_edge_detect.sv
// Rising-edge detector for one cpu stage strobe: a history flop and an AND.
module strobe_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic strobe,
    output logic rise
);

    logic strobe_prev_reg;

    // Remember the strobe level seen at the previous clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) strobe_prev_reg <= 1'b0;
        else      strobe_prev_reg <= strobe;
    end

    assign rise = strobe & ~strobe_prev_reg;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: turns the cpu's fetch/load/store strobes into
// accesses on one single-port synchronous RAM, serving store > load > fetch.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int W      = WORD_WIDTH,
    parameter int AW     = RAM_ADDR_W,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    mem_responder_if.slave      bus,
    output logic                ram_en,
    output logic [BE_WIDTH-1:0] ram_we,
    output logic [AW-1:0]       ram_addr,
    output logic [W-1:0]        ram_wdata,
    input  logic [W-1:0]        ram_rdata
);

    localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);

    // Strobe edge detection, bit 0 fetch, bit 1 load, bit 2 store.
    logic [2:0] strobe_vec;
    logic [2:0] rise_vec;

    assign strobe_vec = {bus.store_clk, bus.load_clk, bus.pc_clk};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_edge
            strobe_edge_detect u_edge (
                .clk    (clk),
                .rst    (rst),
                .strobe (strobe_vec[gi]),
                .rise   (rise_vec[gi])
            );
        end
    endgenerate

    logic fetch_rise;
    logic load_rise;
    logic store_rise;

    assign fetch_rise = rise_vec[0];
    assign load_rise  = rise_vec[1] & bus.load_en;
    assign store_rise = rise_vec[2] & bus.store_en;

    // Pending requests with their captured word addresses and store payload.
    logic                fetch_pend_reg;
    logic [AW-1:0]       fetch_addr_reg;
    logic                load_pend_reg;
    logic [AW-1:0]       load_addr_reg;
    logic                store_pend_reg;
    logic [AW-1:0]       store_addr_reg;
    logic [W-1:0]        store_data_reg;
    logic [BE_WIDTH-1:0] store_be_reg;
    logic                addr_err_reg;

    // FSM and output registers.
    mem_state_t          state_reg;
    req_kind_t           kind_reg;
    logic [1:0]          lat_cnt_reg;
    logic [W-1:0]        inst_reg;
    logic [W-1:0]        l_data_reg;

    // Completion of the request currently in service.
    logic fetch_clr;
    logic load_clr;
    logic store_clr;

    assign fetch_clr = (state_reg == ST_WAIT) && (lat_cnt_reg == 2'd0) && (kind_reg == REQ_FETCH);
    assign load_clr  = (state_reg == ST_WAIT) && (lat_cnt_reg == 2'd0) && (kind_reg == REQ_LOAD);
    assign store_clr = (state_reg == ST_ACCESS) && (kind_reg == REQ_STORE);

    // Address bits above the RAM word range are intentionally dropped (wrap).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.pc[W-1:AW+2], bus.l_addr[W-1:AW+2], bus.s_addr[W-1:AW+2]};

    // Capture requests on strobe edges; a fresh edge wins over a same-edge clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pend_reg <= 1'b0;
            fetch_addr_reg <= '0;
            load_pend_reg  <= 1'b0;
            load_addr_reg  <= '0;
            store_pend_reg <= 1'b0;
            store_addr_reg <= '0;
            store_data_reg <= '0;
            store_be_reg   <= '0;
            addr_err_reg   <= 1'b0;
        end else begin
            if (fetch_rise) begin
                fetch_pend_reg <= 1'b1;
                fetch_addr_reg <= bus.pc[AW+1:2];
            end else if (fetch_clr) begin
                fetch_pend_reg <= 1'b0;
            end

            if (load_rise) begin
                load_pend_reg <= 1'b1;
                load_addr_reg <= bus.l_addr[AW+1:2];
            end else if (load_clr) begin
                load_pend_reg <= 1'b0;
            end

            if (store_rise) begin
                store_pend_reg <= 1'b1;
                store_addr_reg <= bus.s_addr[AW+1:2];
                store_data_reg <= bus.s_data;
                store_be_reg   <= bus.s_be;
            end else if (store_clr) begin
                store_pend_reg <= 1'b0;
            end

            if ((fetch_rise && misaligned(bus.pc[1:0])) ||
                (load_rise  && misaligned(bus.l_addr[1:0])) ||
                (store_rise && misaligned(bus.s_addr[1:0]))) begin
                addr_err_reg <= 1'b1;
            end
        end
    end

    // Access sequencer. Read data is loaded into inst/l_data on the edge that
    // leaves WAIT, so DONE is the cycle in which the new value is already
    // visible; DONE then returns to IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= ST_IDLE;
            kind_reg    <= REQ_FETCH;
            lat_cnt_reg <= 2'd0;
            ram_en      <= 1'b0;
            ram_we      <= '0;
            ram_addr    <= '0;
            ram_wdata   <= '0;
            inst_reg    <= '0;
            l_data_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (store_pend_reg) begin
                        kind_reg  <= REQ_STORE;
                        ram_en    <= 1'b1;
                        ram_we    <= store_be_reg;
                        ram_addr  <= store_addr_reg;
                        ram_wdata <= store_data_reg;
                        state_reg <= ST_ACCESS;
                    end else if (load_pend_reg) begin
                        kind_reg  <= REQ_LOAD;
                        ram_en    <= 1'b1;
                        ram_we    <= '0;
                        ram_addr  <= load_addr_reg;
                        state_reg <= ST_ACCESS;
                    end else if (fetch_pend_reg) begin
                        kind_reg  <= REQ_FETCH;
                        ram_en    <= 1'b1;
                        ram_we    <= '0;
                        ram_addr  <= fetch_addr_reg;
                        state_reg <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    ram_en      <= 1'b0;
                    ram_we      <= '0;
                    lat_cnt_reg <= LAT_INIT;
                    state_reg   <= (kind_reg == REQ_STORE) ? ST_IDLE : ST_WAIT;
                end
                ST_WAIT: begin
                    if (lat_cnt_reg == 2'd0) begin
                        if (kind_reg == REQ_LOAD) l_data_reg <= ram_rdata;
                        else                      inst_reg   <= ram_rdata;
                        state_reg <= ST_DONE;
                    end else begin
                        lat_cnt_reg <= lat_cnt_reg - 2'd1;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.inst     = inst_reg;
    assign bus.l_data   = l_data_reg;
    assign bus.addr_err = addr_err_reg;
    assign bus.busy     = (state_reg != ST_IDLE) | fetch_pend_reg | load_pend_reg | store_pend_reg;

endmodule
